pc_fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the dynamic-pipeline MIPS CPU. Owns the program counter and drives the instruction-memory request/acknowledge handshake. Applies pipeline stalls and arbitrates redirects: exception over branch over jump over sequential. Presents each accepted fetch to IF/ID as a one-cycle valid pulse tagged with its PC.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_fetch_ctrl_if.sv | 11 +
 rtl/pc_redirect_arb.sv | 47 ++++
 rtl/pc_fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared constants and FSM state encoding for the fetch-stage PC sequencer.
package pc_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } pc_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and imem.
interface pc_fetch_ctrl_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;

    modport master (output req, output addr, input ack);
    modport slave  (input req, input addr, output ack);

endinterface

// File: rtl/pc_redirect_arb.sv
// Priority select of the redirect source: exception > eret > branch > jump.
// Exception/eret inputs exist only when PC_EXC_EN is defined.
module pc_redirect_arb
    import pc_pkg::*;
`ifdef PC_EXC_EN
#(
    parameter logic [31:0] EXC_VECTOR = pc_pkg::EXC_VECTOR
)
`endif
(
`ifdef PC_EXC_EN
    input  logic        exc_valid_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
`endif
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_valid_i,
    input  logic [31:0] jmp_target_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_target_o
);

    logic [31:0] raw_target;

    always_comb begin
        redirect_valid_o = 1'b1;
        raw_target       = 32'h0;
`ifdef PC_EXC_EN
        if (exc_valid_i) begin
            raw_target = EXC_VECTOR;
        end else if (eret_i) begin
            raw_target = epc_i;
        end else
`endif
        if (br_taken_i) begin
            raw_target = br_target_i;
        end else if (jmp_valid_i) begin
            raw_target = jmp_target_i;
        end else begin
            redirect_valid_o = 1'b0;
        end
    end

    assign redirect_target_o = word_align(raw_target);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the imem handshake, applies stalls
// and redirects. Optional exception support is enabled by defining PC_EXC_EN.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = pc_pkg::RESET_PC
`ifdef PC_EXC_EN
   ,parameter logic [31:0] EXC_VECTOR = pc_pkg::EXC_VECTOR
`endif
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    br_taken_i,
    input  logic [31:0]             br_target_i,
    input  logic                    jmp_valid_i,
    input  logic [31:0]             jmp_target_i,
    pc_fetch_ctrl_if.master         imem,
    output logic                    if_valid_o,
    output logic [31:0]             if_pc_o
`ifdef PC_EXC_EN
   ,input  logic                    exc_valid_i,
    input  logic [31:0]             exc_pc_i,
    input  logic                    eret_i,
    output logic [31:0]             epc_o
`endif
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ack;
`ifdef PC_EXC_EN
    logic [31:0] epc_q, epc_d;
`endif

    pc_redirect_arb
`ifdef PC_EXC_EN
        #(.EXC_VECTOR(EXC_VECTOR))
`endif
    u_arb (
`ifdef PC_EXC_EN
        .exc_valid_i       (exc_valid_i),
        .eret_i            (eret_i),
        .epc_i             (epc_q),
`endif
        .br_taken_i        (br_taken_i),
        .br_target_i       (br_target_i),
        .jmp_valid_i       (jmp_valid_i),
        .jmp_target_i      (jmp_target_i),
        .redirect_valid_o  (redirect_valid),
        .redirect_target_o (redirect_target)
    );

    // The ack only counts against a request that is actually on the bus.
    assign ack = req_q & imem.ack;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        if_valid_d = 1'b0;
        if_pc_d    = if_pc_q;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    if (ack) begin
                        pc_d = redirect_target;
                    end else begin
                        pending_d = redirect_target;
                        state_d   = FLUSH;
                    end
                end else if (ack) begin
                    if (stall_i) begin
                        state_d = STALL;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        pc_d       = pc_q + 32'd4;
                    end
                end
            end
            STALL: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = FETCH;
                end
            end
            FLUSH: begin
                // Old request must complete before the new target is issued.
                if (ack) begin
                    pc_d    = redirect_valid ? redirect_target : pending_q;
                    state_d = FETCH;
                end else if (redirect_valid) begin
                    pending_d = redirect_target;
                end
            end
            default: state_d = BOOT;
        endcase
        req_d  = (state_d == FETCH) || (state_d == FLUSH);
        addr_d = pc_d;
    end

`ifdef PC_EXC_EN
    always_comb begin
        epc_d = epc_q;
        if (exc_valid_i) begin
            epc_d = exc_pc_i;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pending_q  <= 32'h0;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0;
`ifdef PC_EXC_EN
            epc_q      <= 32'h0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
`ifdef PC_EXC_EN
            epc_q      <= epc_d;
`endif
        end
    end

    assign imem.req   = req_q;
    assign imem.addr  = addr_q;
    assign if_valid_o = if_valid_q;
    assign if_pc_o    = if_pc_q;
`ifdef PC_EXC_EN
    assign epc_o      = epc_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed vector bench for pc_fetch_ctrl; exception checks run when PC_EXC_EN is defined.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        if_valid;
    logic [31:0] if_pc;
`ifdef PC_EXC_EN
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        eret;
    logic [31:0] epc;
`endif

    int n_vec = 0;
    int n_err = 0;

    pc_fetch_ctrl_if imem_bus ();

    pc_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .jmp_valid_i  (jmp_valid),
        .jmp_target_i (jmp_target),
        .imem         (imem_bus.master),
        .if_valid_o   (if_valid),
        .if_pc_o      (if_pc)
`ifdef PC_EXC_EN
       ,.exc_valid_i  (exc_valid),
        .exc_pc_i     (exc_pc),
        .eret_i       (eret),
        .epc_o        (epc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ack;
        logic        br;
        logic [31:0] br_t;
        logic        jmp;
        logic [31:0] jmp_t;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(logic s, logic a, logic b, logic [31:0] bt, logic j,
                                logic [31:0] jt, logic r, logic [31:0] ad, logic v,
                                logic [31:0] p);
        vec_t t;
        t.stall = s; t.ack = a; t.br = b; t.br_t = bt; t.jmp = j; t.jmp_t = jt;
        t.req = r; t.addr = ad; t.v = v; t.pc = p;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic r, input logic [31:0] a,
                           input logic v, input logic [31:0] p);
        chk({tag, " req"},      {31'h0, imem_bus.req}, {31'h0, r});
        chk({tag, " addr"},     imem_bus.addr, a);
        chk({tag, " if_valid"}, {31'h0, if_valid}, {31'h0, v});
        chk({tag, " if_pc"},    if_pc, p);
        $display("%s: req=%b addr=%h if_valid=%b if_pc=%h", tag, imem_bus.req,
                 imem_bus.addr, if_valid, if_pc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; br_taken = 0; br_target = 0; jmp_valid = 0; jmp_target = 0;
        imem_bus.ack = 0;
`ifdef PC_EXC_EN
        exc_valid = 0; exc_pc = 0; eret = 0;
`endif
    endtask

    initial begin
        //             stall ack br  br_t          jmp jmp_t        req addr          v  if_pc
        vecs[0]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00400000, 0, 32'h0);
        vecs[1]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00400004, 1, 32'h00400000);
        vecs[2]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00400008, 1, 32'h00400004);
        vecs[3]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h00400008, 0, 32'h00400004);
        vecs[4]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h00400008, 0, 32'h00400004);
        vecs[5]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h00400008, 0, 32'h00400004);
        vecs[6]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0040000C, 1, 32'h00400008);
        vecs[7]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0040000C, 0, 32'h00400008);
        vecs[8]  = mk(0, 0, 1, 32'h00400103, 0, 32'h0,        1, 32'h0040000C, 0, 32'h00400008);
        vecs[9]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0040000C, 0, 32'h00400008);
        vecs[10] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00400100, 0, 32'h00400008);
        vecs[11] = mk(0, 1, 1, 32'h00400200, 1, 32'h00400300, 1, 32'h00400200, 0, 32'h00400008);
        vecs[12] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00400204, 1, 32'h00400200);
        vecs[13] = mk(0, 0, 0, 32'h0,        1, 32'h00400302, 1, 32'h00400204, 0, 32'h00400200);
        vecs[14] = mk(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,        1, 32'h00400204, 0, 32'h00400200);
        vecs[15] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h00400200);
        vecs[16] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00000000, 1, 32'hFFFFFFFC);
        vecs[17] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00000004, 1, 32'h00000000);
        vecs[18] = mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h00000004, 0, 32'h00000000);
        vecs[19] = mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h00000004, 0, 32'h00000000);
        vecs[20] = mk(1, 0, 0, 32'h0,        1, 32'h00000800, 1, 32'h00000800, 0, 32'h00000000);
        vecs[21] = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h00000804, 1, 32'h00000800);
        vecs[22] = mk(0, 0, 1, 32'h00400500, 0, 32'h0,        1, 32'h00000804, 0, 32'h00000800);

        rst = 1'b1;
        idle_inputs();
        step();
        step();
        chk_out("reset", 1'b0, 32'h00400000, 1'b0, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            stall        = vecs[i].stall;
            imem_bus.ack = vecs[i].ack;
            br_taken     = vecs[i].br;
            br_target    = vecs[i].br_t;
            jmp_valid    = vecs[i].jmp;
            jmp_target   = vecs[i].jmp_t;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].v, vecs[i].pc);
        end

        // Now in FLUSH with a request outstanding: reset must drop it without a clock edge.
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 32'h00400000, 1'b0, 32'h0);
        step();
        rst = 1'b0;
        imem_bus.ack = 1'b1;
        #1;
        chk_out("boot", 1'b0, 32'h00400000, 1'b0, 32'h0);
        step();
        chk_out("post_rst0", 1'b1, 32'h00400000, 1'b0, 32'h0);
        step();
        chk_out("post_rst1", 1'b1, 32'h00400004, 1'b1, 32'h00400000);
        step();
        chk_out("post_rst2", 1'b1, 32'h00400008, 1'b1, 32'h00400004);

`ifdef PC_EXC_EN
        exc_valid = 1; exc_pc = 32'h00400ABC; eret = 1;
        br_taken = 1; br_target = 32'h00400200; jmp_valid = 1; jmp_target = 32'h00400300;
        step();
        chk_out("exc", 1'b1, 32'h00400004, 1'b0, 32'h00400004);
        chk("exc epc", epc, 32'h00400ABC);
        exc_valid = 0; exc_pc = 0; jmp_valid = 0;
        step();
        chk_out("eret", 1'b1, 32'h00400ABC, 1'b0, 32'h00400004);
        eret = 0; br_taken = 0;
        step();
        chk_out("eret_fetch", 1'b1, 32'h00400AC0, 1'b1, 32'h00400ABC);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
